// File: rtl/sipo_deframer_pkg.sv
// Shared types and frame-level constants for the sipo_deframer receiver.
package sipo_deframer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

  // Zero-extension leaves the XOR unchanged, so any word up to 32 bits fits.
  function automatic logic xor_reduce(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/sipo_deframer_out_reg.sv
// One-entry valid/ready holding register for received words, with overrun pulse.
module deframer_out_reg
  import sipo_deframer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              overrun
);

  logic [DATA_W-1:0] data_r;
  logic              valid_r;
  logic              overrun_r;

  // Load, drain or drop a word; a new word may replace one being drained in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r    <= '0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= 1'b0;
      if (load) begin
        if (!valid_r || out_ready) begin
          data_r  <= word;
          valid_r <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (valid_r && out_ready) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign out_data  = data_r;
  assign out_valid = valid_r;
  assign overrun   = overrun_r;

endmodule

// File: rtl/sipo_deframer.sv
// Serial-in parallel-out deframer: start bit, DATA_W bits LSB first, optional parity, stop bit.
// Parity stage is compiled in with SIPO_DEFRAMER_PARITY_EN.
module sipo_deframer
  import sipo_deframer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);

  localparam int CNT_W = ($clog2(DATA_W) > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  if (DATA_W < 2 || DATA_W > 32) begin : g_bad_width
    $error("sipo_deframer: DATA_W must be in 2..32");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_sense
    $error("sipo_deframer: PARITY_ODD must be 0 or 1");
  end
  if (START_BIT == IDLE_LEVEL) begin : g_bad_levels
    $error("sipo_deframer: start bit must differ from the idle level");
  end

`ifdef SIPO_DEFRAMER_PARITY_EN
  localparam state_e AFTER_DATA = PARITY;
`else
  localparam state_e AFTER_DATA = STOP;
`endif

  state_e            state_r, state_s;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [DATA_W-1:0] shift_r;
  logic              par_bad_s;
  logic              good_s, frame_err_s, parity_err_s;
  logic              frame_err_r, parity_err_r;

`ifdef SIPO_DEFRAMER_PARITY_EN
  logic par_bad_r;
  logic par_exp_s;
  assign par_exp_s = xor_reduce(32'(shift_r)) ^ 1'(PARITY_ODD);

  // Latch a parity mismatch for the stop-bit decision; cleared by each new start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bad_r <= 1'b0;
    end else if (state_r == IDLE) begin
      par_bad_r <= 1'b0;
    end else if (state_r == PARITY) begin
      par_bad_r <= (sin != par_exp_s);
    end else begin
      par_bad_r <= par_bad_r;
    end
  end
  assign par_bad_s = par_bad_r;
`else
  assign par_bad_s = 1'b0;
`endif

  // Next-state and stop-bit verdict.
  always_comb begin
    state_s      = state_r;
    good_s       = 1'b0;
    frame_err_s  = 1'b0;
    parity_err_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (sin == START_BIT) state_s = DATA;
        else                  state_s = IDLE;
      end
      DATA: begin
        if (bit_cnt_r == LAST_BIT) state_s = AFTER_DATA;
        else                       state_s = DATA;
      end
      PARITY: state_s = STOP;
      STOP: begin
        state_s      = IDLE;
        frame_err_s  = (sin != STOP_BIT);
        parity_err_s = par_bad_s;
        good_s       = (sin == STOP_BIT) && !par_bad_s;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Bit counter, shifter and registered error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_r    <= '0;
      shift_r      <= '0;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      frame_err_r  <= frame_err_s;
      parity_err_r <= parity_err_s;
      case (state_r)
        IDLE: bit_cnt_r <= '0;
        DATA: begin
          shift_r[bit_cnt_r] <= sin;
          bit_cnt_r          <= bit_cnt_r + CNT_W'(1);
        end
        default: bit_cnt_r <= bit_cnt_r;
      endcase
    end
  end

  deframer_out_reg #(.DATA_W(DATA_W)) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (good_s),
    .word      (shift_r),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

  assign frame_err  = frame_err_r;
  assign parity_err = parity_err_r;

endmodule

// File: tb/tb_sipo_deframer.sv
// Self-checking bench for sipo_deframer: directed frame table, reset abort, random frames vs. a frame-level model.
module tb_sipo_deframer;

  localparam int DW = 8;
`ifdef SIPO_DEFRAMER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          sin;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_valid, frame_err, overrun, parity_err;

  always #5 clk = ~clk;

  sipo_deframer #(.DATA_W(DW), .PARITY_ODD(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  int checks   = 0;
  int failures = 0;

  // Frame-level reference state: what the consumer should see.
  logic [DW-1:0] exp_data;
  logic          exp_valid, exp_ferr, exp_ovr, exp_perr;

  typedef struct {
    logic [DW-1:0] data;
    logic          stop;
    bit            flip;
    int            mode;
    int            gap;
    bit            eferr;
    bit            eperr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic check_all();
    chk("out_valid",  32'(out_valid),  32'(exp_valid));
    chk("out_data",   32'(out_data),   32'(exp_data));
    chk("frame_err",  32'(frame_err),  32'(exp_ferr));
    chk("overrun",    32'(overrun),    32'(exp_ovr));
    chk("parity_err", 32'(parity_err), 32'(exp_perr));
  endtask

  task automatic model_reset();
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_ferr  = 1'b0;
    exp_ovr   = 1'b0;
    exp_perr  = 1'b0;
  endtask

  // One clock: drive, let the edge happen, update the model, compare on the falling edge.
  task automatic step(input logic s, input logic r, input bit done, input bit ferr,
                      input bit perr, input logic [DW-1:0] w);
    sin       = s;
    out_ready = r;
    @(posedge clk);
    exp_ferr = done && ferr;
    exp_perr = done && perr;
    exp_ovr  = 1'b0;
    if (done && !ferr && !perr) begin
      if (!exp_valid || r) begin
        exp_data  = w;
        exp_valid = 1'b1;
      end else begin
        exp_ovr = 1'b1;
      end
    end else if (exp_valid && r) begin
      exp_valid = 1'b0;
    end
    @(negedge clk);
    check_all();
  endtask

  function automatic logic pick_ready(input int mode, input bit is_stop);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'($urandom_range(0, 1));
      3:       return is_stop;
      default: return 1'b1;
    endcase
  endfunction

  task automatic send_frame(input vec_t v);
    step(1'b1, pick_ready(v.mode, 1'b0), 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < DW; i++)
      step(v.data[i], pick_ready(v.mode, 1'b0), 1'b0, 1'b0, 1'b0, '0);
    if (PAR_EN)
      step((^v.data) ^ v.flip, pick_ready(v.mode, 1'b0), 1'b0, 1'b0, 1'b0, '0);
    step(v.stop, pick_ready(v.mode, 1'b1), 1'b1, v.eferr, v.eperr, v.data);
    for (int g = 0; g < v.gap; g++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    vec_t v;
    rst       = 1'b1;
    sin       = 1'b0;
    out_ready = 1'b0;
    model_reset();

    // {data, stop, flip, ready mode, trailing idle cycles, frame_err?, parity_err?}
    tbl.push_back('{8'hA5, 1'b0, 1'b0, 1, 2, 1'b0, 1'b0});
    tbl.push_back('{8'hA5, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0});
    tbl.push_back('{8'h3C, 1'b0, 1'b0, 0, 2, 1'b0, 1'b0});
    tbl.push_back('{8'h5A, 1'b1, 1'b0, 1, 0, 1'b1, 1'b0});
    tbl.push_back('{8'h01, 1'b0, 1'b0, 1, 2, 1'b0, 1'b0});
    tbl.push_back('{8'h12, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0});
    tbl.push_back('{8'h34, 1'b0, 1'b0, 3, 2, 1'b0, 1'b0});
    tbl.push_back('{8'hFF, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0});
    tbl.push_back('{8'h80, 1'b0, 1'b0, 2, 1, 1'b0, 1'b0});
`ifdef SIPO_DEFRAMER_PARITY_EN
    tbl.push_back('{8'h03, 1'b0, 1'b1, 1, 2, 1'b0, 1'b1});
    tbl.push_back('{8'h03, 1'b0, 1'b0, 1, 2, 1'b0, 1'b0});
    tbl.push_back('{8'h07, 1'b1, 1'b1, 1, 2, 1'b1, 1'b1});
`endif

    @(negedge clk);
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b0;

    foreach (tbl[k]) send_frame(tbl[k]);

    // Abort a 0xFF frame after four data bits; no partial word may appear.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b0;
    v = '{8'hFF, 1'b0, 1'b0, 1, 3, 1'b0, 1'b0};
    send_frame(v);

    for (int n = 0; n < 150; n++) begin
      v.data  = DW'($urandom);
      v.stop  = ($urandom_range(0, 7) == 0);
      v.flip  = PAR_EN && ($urandom_range(0, 5) == 0);
      v.mode  = $urandom_range(0, 2);
      v.gap   = $urandom_range(0, 2);
      v.eferr = v.stop;
      v.eperr = v.flip;
      send_frame(v);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sipo_deframer.md
Name: sipo_deframer

Overview:
- Serial-in, parallel-out receiver that sits directly downstream of the serial shift-register stage and consumes its single-bit output stream.
- Detects a start bit, collects DATA_W data bits LSB-first, and checks the stop bit.
- Presents each good word on a one-entry valid/ready output register.
- Flags framing errors and overruns as one-cycle pulses.

Parameters:
- DATA_W, 8, number of data bits per frame; legal range 2..32.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
- clk  input  1  rising-edge clock; sin is sampled on every edge.
- rst  input  1  reset, asynchronous, active-high.
- sin  input  1  serial data in; idle level is 0.
- out_data  output  DATA_W  received word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready on a clock edge.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 1.
- overrun  output  1  one-cycle pulse: a good frame completed while the output register was full and not being drained.
- parity_err  output  1  one-cycle pulse: parity mismatch; tied 0 when parity is not compiled in.

Behaviour:
- Frame format: start bit = 1, then DATA_W data bits LSB first, then [parity bit], then stop bit = 0. One bit per clock.
- Reset values: state IDLE, bit_cnt 0, shift register 0, out_data 0, out_valid 0, frame_err/overrun/parity_err 0.
- Reset asserted mid-frame aborts the frame immediately; no partial word is ever emitted.
- FSM states: IDLE, DATA, PARITY (compiled in only), STOP.
  - IDLE: sin=1 -> DATA, bit_cnt=0. sin=0 -> stay in IDLE.
  - DATA: shift sin into the bit at position bit_cnt; bit_cnt++. At bit_cnt==DATA_W-1 -> PARITY if compiled in, else STOP.
  - PARITY: compare sin with the computed parity; latch the mismatch; -> STOP.
  - STOP, sin=0 with no latched parity mismatch -> good frame; -> IDLE.
  - STOP, sin=1 -> frame_err pulses on the next cycle; word discarded; -> IDLE. That 1 is not treated as a new start bit.
  - STOP with a latched parity mismatch -> parity_err pulses; word discarded; -> IDLE. If sin=1 as well, frame_err also pulses.
- bit_cnt width is max(1, $clog2(DATA_W)).
- Latency:
  - With start sampled at edge N, the stop bit is sampled at edge N+DATA_W+1 (+1 with parity).
  - out_data/out_valid update on the stop-sampling edge, so they are visible in the following cycle.
- Back-to-back frames: a start bit may be presented in the cycle immediately after the stop bit (IDLE lasts one cycle minimum).
- Output register rules on a good frame:
  - out_valid=0 -> load the word, set out_valid=1.
  - out_valid=1 && out_ready=1 in the same cycle -> the old word is consumed and the new word is loaded; out_valid stays 1; no overrun.
  - out_valid=1 && out_ready=0 -> new word dropped; out_data unchanged; overrun pulses one cycle.
- Without a good frame: out_valid && out_ready clears out_valid. out_data holds its last value.
- Error pulses are registered and last exactly one cycle. They are independent of out_ready.

Optional Feature:
- Macro: SIPO_DEFRAMER_PARITY_EN.
- Defined:
  - PARITY state is present; frame is DATA_W+3 bits.
  - Parity = XOR of data bits, XOR PARITY_ODD.
  - Mismatch -> parity_err pulse, word discarded.
- Undefined:
  - No PARITY state; frame is DATA_W+2 bits.
  - parity_err tied 0; PARITY_ODD ignored.

Decomposition:
- Package sipo_deframer_pkg holds:
  - state enum (IDLE, DATA, PARITY, STOP);
  - constants START_BIT=1'b1, STOP_BIT=1'b0, IDLE_LEVEL=1'b0.
- One sub-module, deframer_out_reg: the one-entry valid/ready holding register with overrun detection. Parameterised by DATA_W.
- The FSM, shifter and parity live in the top module.

Test Plan:
- DATA_W=8, out_ready=1, sin = 1, 1,0,1,0,0,1,0,1, 0 -> out_data=0xA5 and out_valid=1 for one cycle after the stop edge; no error pulses.
- out_ready=0, frame 0xA5 then back-to-back frame 0x3C -> out_data stays 0xA5 with out_valid held; overrun pulses once. Then out_ready=1 -> out_valid clears after one edge.
- Frame 0x5A with stop bit = 1 -> frame_err pulses once; out_valid stays 0; an immediately following frame 0x01 is received correctly.
- rst asserted after 4 data bits of 0xFF, released, then a full 0xFF frame -> all outputs 0 during reset; afterwards out_data=0xFF exactly once.
- Two back-to-back good frames 0x12, 0x34 with out_ready=1 only in the cycle the second completes -> out_valid continuous; 0x34 replaces 0x12; no overrun.
- With SIPO_DEFRAMER_PARITY_EN, PARITY_ODD=0, data 0x03 with parity bit 1 -> parity_err pulses; no out_valid. Same frame with parity bit 0 -> 0x03 delivered.
